// File: rtl/noise_burst_sched_pkg.sv
// noise_pkg: shared encodings for the noise burst sequencer and noise consumers.
//  state_t   : sequencer FSM states
//  RATE_*    : noise_choose rate codes (0 is illegal)
//  CNT_W_DEF : default counter width
package noise_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_BURST,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [1:0] RATE_200 = 2'd1;
   localparam logic [1:0] RATE_100 = 2'd2;
   localparam logic [1:0] RATE_50  = 2'd3;

   localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/noise_burst_sched_if.sv
// Burst command channel, valid/ready handshake.
//  master: drives cmd_valid and the command fields, sees cmd_ready
//  slave : sees cmd_valid and the fields, drives cmd_ready
interface noise_burst_sched_if #(parameter int CNT_W = noise_pkg::CNT_W_DEF);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [9:0]       cmd_density;
   logic [1:0]       cmd_rate;
   logic [CNT_W-1:0] cmd_burst;
   logic [CNT_W-1:0] cmd_gap;
   logic [7:0]       cmd_repeat;

   modport master (output cmd_valid, cmd_density, cmd_rate, cmd_burst, cmd_gap, cmd_repeat,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_density, cmd_rate, cmd_burst, cmd_gap, cmd_repeat,
                   output cmd_ready);
endinterface

// File: rtl/noise_burst_sched_edge_sync.sv
// noise_edge_sync: brings an asynchronous noise wave into the local clock domain
// and emits a one-cycle pulse per rising edge.
//  clk    : destination clock
//  rst    : async active-low reset
//  din    : asynchronous input
//  rise_o : high for one cycle, two clocks after din rises (consumer registers it on the third)
module noise_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_o
);
   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = din;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end

   // s1/s2 are the synchroniser; s3 is only history for edge detection
   assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/noise_burst_sched.sv
// noise_burst_sched: sequences one burst command into the noise generator.
//  clk_200, rst      : clock and async active-low reset
//  cmd               : command channel (slave side)
//  abort             : level, ends any active command
//  noise_in          : async noise wave from the generator
//  total_out         : generator threshold, {6'b0,density} while active
//  noise_choose_out  : generator rate select, {6'b0,rate} while active
//  gate/busy/done/err: status, all registered
//  pulse_cnt         : edges counted in the current burst
module noise_burst_sched
   import noise_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SETTLE_CYC = 8,
   parameter int TIMEOUT    = 65535
) (
   input  logic              clk_200,
   input  logic              rst,
   noise_burst_sched_if.slave cmd,
   input  logic              abort,
   input  logic              noise_in,
   output logic [15:0]       total_out,
   output logic [7:0]        noise_choose_out,
   output logic              gate,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  pulse_cnt
);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [15:0]      total_q, total_d;
   logic [7:0]       choose_q, choose_d;
   logic             gate_q, gate_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [CNT_W-1:0] pulse_q, pulse_d, burst_q, burst_d, gap_q, gap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, tmo_q, tmo_d, pulse_inc;
   logic [7:0]       reps_q, reps_d;
   logic             rise;

   noise_edge_sync u_sync (.clk(clk_200), .rst(rst), .din(noise_in), .rise_o(rise));

   assign cmd.cmd_ready = (state_q == ST_IDLE);
   assign pulse_inc     = pulse_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      total_d  = total_q;
      choose_d = choose_q;
      pulse_d  = pulse_q;
      burst_d  = burst_q;
      gap_d    = gap_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      reps_d   = reps_q;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE:
            if (cmd.cmd_valid) begin
               if (cmd.cmd_rate == 2'd0) err_d = 1'b1;
               else begin
                  total_d  = {6'b0, cmd.cmd_density};
                  choose_d = {6'b0, cmd.cmd_rate};
                  burst_d  = cmd.cmd_burst;
                  gap_d    = cmd.cmd_gap;
                  reps_d   = (cmd.cmd_repeat == 8'd0) ? 8'd1 : cmd.cmd_repeat;
                  cnt_d    = '0;
                  state_d  = ST_SETTLE;
               end
            end
         ST_SETTLE:
            if (abort) state_d = ST_DONE;
            else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_BURST;
               pulse_d = '0;
               tmo_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         ST_BURST:
            if (abort) state_d = ST_DONE;
            else if (rise) begin
               tmo_d = '0;
               if (pulse_q != '1) pulse_d = pulse_inc;
               if (burst_q != '0 && pulse_inc == burst_q) begin
                  reps_d = reps_q - 8'd1;
                  if (reps_q == 8'd1) state_d = ST_DONE;
                  else if (gap_q == '0) pulse_d = '0;   // back-to-back burst
                  else begin
                     state_d = ST_GAP;
                     cnt_d   = '0;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else tmo_d = tmo_q + 1'b1;
         ST_GAP:
            if (abort) state_d = ST_DONE;
            else if (cnt_q == gap_q - 1'b1) begin
               state_d = ST_BURST;
               pulse_d = '0;
               tmo_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // status flops track the next state so they line up with state_q
      if (state_d == ST_DONE) begin
         total_d  = '0;
         choose_d = '0;
      end
      done_d = (state_d == ST_DONE);
      gate_d = (state_d == ST_BURST);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_200 or negedge rst)
      if (!rst) begin
         state_q  <= ST_IDLE;
         total_q  <= '0;
         choose_q <= '0;
         gate_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         pulse_q  <= '0;
         burst_q  <= '0;
         gap_q    <= '0;
         cnt_q    <= '0;
         tmo_q    <= '0;
         reps_q   <= '0;
      end else begin
         state_q  <= state_d;
         total_q  <= total_d;
         choose_q <= choose_d;
         gate_q   <= gate_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         pulse_q  <= pulse_d;
         burst_q  <= burst_d;
         gap_q    <= gap_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         reps_q   <= reps_d;
      end

   assign total_out        = total_q;
   assign noise_choose_out = choose_q;
   assign gate             = gate_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
   assign pulse_cnt        = pulse_q;
endmodule

// File: tb/tb_noise_burst_sched.sv
module tb_noise_burst_sched;
   localparam int CNT_W = 16;
   localparam int SETTLE_CYC = 8;
   localparam int TIMEOUT = 50;

   typedef struct {
      int err;
      int win;
      int pc;    // -1 = don't care
      int gap;   // -1 = don't care
      int blen;  // -1 = don't care, else cycles from last gate rise to done
   } exp_t;

   logic clk_200 = 1'b0;
   logic rst = 1'b0;
   logic abort = 1'b0;
   logic noise_en = 1'b0;
   logic noise_man = 1'b0;
   logic gen_q = 1'b0;
   logic noise_in;
   logic [15:0] total_out;
   logic [7:0] noise_choose_out;
   logic gate, busy, done, err;
   logic [CNT_W-1:0] pulse_cnt;

   int n_chk = 0;
   int n_err = 0;
   exp_t sb[$];

   noise_burst_sched_if #(.CNT_W(CNT_W)) bus ();

   noise_burst_sched #(.CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk_200(clk_200), .rst(rst), .cmd(bus), .abort(abort), .noise_in(noise_in),
      .total_out(total_out), .noise_choose_out(noise_choose_out), .gate(gate),
      .busy(busy), .done(done), .err(err), .pulse_cnt(pulse_cnt));

   always #5 clk_200 = ~clk_200;

   // free-running noise: 3 high / 3 low, one rising edge every 6 cycles
   int ph = 0;
   always @(negedge clk_200) begin
      ph <= (ph == 5) ? 0 : ph + 1;
      gen_q <= (ph < 3);
   end
   assign noise_in = noise_en ? gen_q : noise_man;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   // monitor: gate windows, gaps, pulse counts, and done-time scoreboard pops
   int mcyc = 0, rise_cyc = 0, fall_cyc = 0, win = 0, last_gap = -1, last_pc = 0;
   logic gate_prev = 1'b0;
   always @(negedge clk_200) begin
      mcyc++;
      if (gate && !gate_prev) begin
         win++;
         if (win > 1) last_gap = mcyc - fall_cyc;
         rise_cyc = mcyc;
      end
      if (!gate && gate_prev) begin
         fall_cyc = mcyc;
         last_pc = int'(pulse_cnt);
         if (sb.size() > 0 && sb[0].pc >= 0) chk("win_pc", last_pc, sb[0].pc);
      end
      gate_prev = gate;
      if (done) begin
         if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_err", int'(err), e.err);
            chk("done_windows", win, e.win);
            if (e.pc >= 0) chk("done_pc", last_pc, e.pc);
            if (e.gap >= 0) chk("gap_len", last_gap, e.gap);
            if (e.blen >= 0) chk("burst_len", mcyc - rise_cyc, e.blen);
            chk("done_total", int'(total_out), 0);
            chk("done_choose", int'(noise_choose_out), 0);
            chk("done_gate", int'(gate), 0);
         end
      end else if (!busy) begin
         win = 0;
         last_gap = -1;
      end
   end

   task automatic send(input int dens, input int rate, input int burst, input int gap, input int rep);
      int k;
      @(negedge clk_200);
      bus.cmd_valid = 1'b1;
      bus.cmd_density = 10'(dens);
      bus.cmd_rate = 2'(rate);
      bus.cmd_burst = CNT_W'(burst);
      bus.cmd_gap = CNT_W'(gap);
      bus.cmd_repeat = 8'(rep);
      k = 0;
      while (!bus.cmd_ready && k < 200) begin
         @(negedge clk_200);
         k++;
      end
      if (k >= 200) chk("ready_timeout", 0, 1);
      @(posedge clk_200);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_sig(input string tag, input int which, input int val);
      int k;
      k = 0;
      forever begin
         @(negedge clk_200);
         k++;
         if ((which == 0 ? int'(gate) : int'(done)) == val) break;
         if (k >= 500) begin
            chk(tag, 0, 1);
            break;
         end
      end
   endtask

   initial begin
      int k;
      exp_t e;
      bus.cmd_valid = 1'b0;
      bus.cmd_density = '0;
      bus.cmd_rate = '0;
      bus.cmd_burst = '0;
      bus.cmd_gap = '0;
      bus.cmd_repeat = '0;
      repeat (3) @(negedge clk_200);
      chk("rst_ready", int'(bus.cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gate", int'(gate), 0);
      chk("rst_outs", int'({done, err, total_out, noise_choose_out, pulse_cnt}), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk_200);

      // 1: two bursts of 4 with a 10-cycle gap
      noise_en = 1'b1;
      e = '{err: 0, win: 2, pc: 4, gap: 10, blen: -1};
      sb.push_back(e);
      send(512, 1, 4, 10, 2);
      @(negedge clk_200);
      chk("t1_total", int'(total_out), 512);
      chk("t1_choose", int'(noise_choose_out), 1);
      chk("t1_busy", int'(busy), 1);
      chk("t1_ready", int'(bus.cmd_ready), 0);
      k = 1;
      while (!gate && k < 100) begin
         @(negedge clk_200);
         k++;
      end
      chk("t1_settle", k, SETTLE_CYC + 1);
      wait_sig("t1_done_timeout", 1, 1);
      @(negedge clk_200);
      chk("t1_idle", int'(busy), 0);

      // 2: illegal rate
      send(100, 0, 4, 0, 1);
      @(negedge clk_200);
      chk("t2_err", int'(err), 1);
      chk("t2_busy", int'(busy), 0);
      chk("t2_total", int'(total_out), 0);
      chk("t2_ready", int'(bus.cmd_ready), 1);
      @(negedge clk_200);
      chk("t2_err_pulse", int'(err), 0);
      chk("t2_nodone", int'(done), 0);

      // 3: endless burst, abort after 100 cycles
      e = '{err: 0, win: 1, pc: -1, gap: -1, blen: -1};
      sb.push_back(e);
      send(300, 3, 0, 0, 1);
      wait_sig("t3_gate_timeout", 0, 1);
      repeat (100) @(negedge clk_200);
      chk("t3_running", int'(gate), 1);
      abort = 1'b1;
      @(negedge clk_200);
      abort = 1'b0;
      chk("t3_done", int'(done), 1);
      chk("t3_err", int'(err), 0);
      chk("t3_total", int'(total_out), 0);
      @(negedge clk_200);

      // 4: edge arriving in the abort cycle
      noise_en = 1'b0;
      e = '{err: 0, win: 1, pc: -1, gap: -1, blen: -1};
      sb.push_back(e);
      send(300, 2, 5, 0, 1);
      wait_sig("t4_gate_timeout", 0, 1);
      noise_man = 1'b1;
      repeat (2) @(negedge clk_200);
      chk("t4_edge_latency", int'(pulse_cnt), 0);
      abort = 1'b1;
      @(negedge clk_200);
      abort = 1'b0;
      noise_man = 1'b0;
      chk("t4_done", int'(done), 1);
      chk("t4_err", int'(err), 0);
      @(negedge clk_200);

      // 5: no noise -> timeout after TIMEOUT cycles of open gate
      e = '{err: 1, win: 1, pc: 0, gap: -1, blen: TIMEOUT};
      sb.push_back(e);
      send(0, 2, 5, 0, 1);
      wait_sig("t5_done_timeout", 1, 1);
      chk("t5_err", int'(err), 1);
      @(negedge clk_200);

      // 6: reset during GAP, then a fresh command
      noise_en = 1'b1;
      send(200, 1, 2, 30, 3);
      wait_sig("t6_gate_timeout", 0, 1);
      wait_sig("t6_gap_timeout", 0, 0);
      @(negedge clk_200);
      rst = 1'b0;
      #1;
      chk("t6_gate", int'(gate), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_ready", int'(bus.cmd_ready), 1);
      chk("t6_total", int'(total_out), 0);
      repeat (3) @(negedge clk_200);
      chk("t6_nodone", int'(done), 0);
      rst = 1'b1;
      e = '{err: 0, win: 1, pc: 3, gap: -1, blen: -1};
      sb.push_back(e);
      send(64, 2, 3, 5, 1);
      wait_sig("t6b_done_timeout", 1, 1);
      repeat (5) @(negedge clk_200);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
